// File: rtl/uart_tx_framer_pkg.sv
// Shared UART transmit definitions: frame parity modes, transmitter states and line rate.
package uart_tx_framer_pkg;

    localparam int CLOCK_FREQ_HZ = 50_000_000;
    localparam int BAUD_RATE     = 115_200;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } tx_parity_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: pulses tick on the last cycle of every CLKS_PER_BIT-cycle period.
// Latency: tick is combinational from the counter; clear holds the count at zero.
// Backpressure: none, free-running while clear is low.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx_framer.sv
// Parametrised UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits.
// Latency: tx falls one cycle after acceptance; frame_done pulses the cycle after the last stop bit.
// Backpressure: tx_ready is low for the whole frame; tx_valid is ignored until it returns.
module uart_tx_framer
    import uart_tx_framer_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE,
    parameter int         DATA_BITS    = 8,
    parameter tx_parity_t PARITY       = PAR_NONE,
    parameter int         STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 frame_done
);

    localparam int IDX_W = $clog2(DATA_BITS);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_framer: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_framer: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_framer: illegal PARITY mode");
    end

    uart_tx_state_t       state;
    logic [DATA_BITS-1:0] shreg;
    logic [IDX_W-1:0]     bit_idx;
    logic                 par_bit;
    logic                 tick;

    // Holding the timer cleared in IDLE guarantees a full-length start bit after acceptance.
    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state == ST_IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            par_bit    <= 1'b0;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shreg    <= tx_data;
                        par_bit  <= (^tx_data) ^ (PARITY == PAR_ODD);
                        bit_idx  <= '0;
                        state    <= ST_START;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            if (PARITY != PAR_NONE) begin
                                state <= ST_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            // Line is registered, so drive the bit that lands in bit 0 after this shift.
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state   <= ST_STOP;
                        bit_idx <= '0;
                        tx      <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                            state      <= ST_IDLE;
                            bit_idx    <= '0;
                            tx_ready   <= 1'b1;
                            tx_busy    <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Drives four framer configurations with directed and random words and compares every
// output, every cycle, against a frame-level model of the expected line waveform.
module tb_uart_tx_framer;
    import uart_tx_framer_pkg::*;

    localparam int N = 4;
    localparam int CPB0 = 4, CPB1 = 4, CPB2 = 3, CPB3 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       vld [N];
    logic [8:0] dat [N];
    logic       tx_ln [N];
    logic       rdy [N];
    logic       bsy [N];
    logic       dn [N];

    uart_tx_framer #(.CLKS_PER_BIT(CPB0), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_data(dat[0][7:0]),
        .tx_ready(rdy[0]), .tx(tx_ln[0]), .tx_busy(bsy[0]), .frame_done(dn[0]));
    uart_tx_framer #(.CLKS_PER_BIT(CPB1), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_data(dat[1][7:0]),
        .tx_ready(rdy[1]), .tx(tx_ln[1]), .tx_busy(bsy[1]), .frame_done(dn[1]));
    uart_tx_framer #(.CLKS_PER_BIT(CPB2), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_data(dat[2][7:0]),
        .tx_ready(rdy[2]), .tx(tx_ln[2]), .tx_busy(bsy[2]), .frame_done(dn[2]));
    uart_tx_framer #(.CLKS_PER_BIT(CPB3), .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .tx_valid(vld[3]), .tx_data(dat[3][6:0]),
        .tx_ready(rdy[3]), .tx(tx_ln[3]), .tx_busy(bsy[3]), .frame_done(dn[3]));

    // Frame format per instance; parity mode 0 = none, 1 = odd, 2 = even.
    int cpb [N];
    int db  [N];
    int pm  [N];
    int sb  [N];

    // Model: each frame is a list of line levels, one per bit period.
    bit          active [N];
    int          start  [N];
    int          flen   [N];
    logic [15:0] fb     [N];

    logic       a_rst;
    logic       a_vld [N];
    logic [8:0] a_dat [N];

    logic [8:0] wbuf [N][64];
    int         wh [N];
    int         wt [N];

    int checks;
    int errors;
    int cyc;
    bit rnd_gate;
    bit rst_hit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int i, input logic [8:0] w);
        wbuf[i][wt[i] % 64] = w;
        wt[i]++;
    endtask

    task automatic model_edge(input int i);
        logic [8:0] w;
        int nb;
        if (a_rst) begin
            active[i] = 1'b0;
        end else if (a_vld[i] && (!active[i] || cyc - 1 >= start[i] + flen[i])) begin
            w = a_dat[i] & ((9'd1 << db[i]) - 9'd1);
            fb[i] = '1;
            fb[i][0] = 1'b0;
            for (int k = 0; k < db[i]; k++) fb[i][1 + k] = w[k];
            nb = 1 + db[i];
            if (pm[i] != 0) begin
                fb[i][nb] = (^w) ^ (pm[i] == 1);
                nb++;
            end
            nb += sb[i];
            start[i]  = cyc;
            flen[i]   = nb * cpb[i];
            active[i] = 1'b1;
            if (wh[i] != wt[i]) wh[i]++;
        end
    endtask

    task automatic check_outputs(input int i);
        bit   inf;
        logic etx;
        logic edn;
        inf = active[i] && cyc >= start[i] && cyc < start[i] + flen[i];
        etx = inf ? fb[i][(cyc - start[i]) / cpb[i]] : 1'b1;
        edn = active[i] && (cyc == start[i] + flen[i]);
        check($sformatf("tx%0d", i), 32'(tx_ln[i]), 32'(etx));
        check($sformatf("tx_ready%0d", i), 32'(rdy[i]), 32'(!inf));
        check($sformatf("tx_busy%0d", i), 32'(bsy[i]), 32'(inf));
        check($sformatf("frame_done%0d", i), 32'(dn[i]), 32'(edn));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (wh[i] != wt[i] && (!rnd_gate || $urandom_range(0, 3) != 0)) begin
                vld[i] = 1'b1;
                dat[i] = wbuf[i][wh[i] % 64];
            end else begin
                vld[i] = 1'b0;
                dat[i] = 9'($urandom);
            end
        end
    endtask

    task automatic step();
        a_rst = rst;
        for (int i = 0; i < N; i++) begin
            a_vld[i] = vld[i];
            a_dat[i] = dat[i];
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            model_edge(i);
            check_outputs(i);
        end
        drive();
    endtask

    initial begin
        cpb = '{CPB0, CPB1, CPB2, CPB3};
        db  = '{8, 8, 8, 7};
        pm  = '{0, 2, 1, 0};
        sb  = '{1, 1, 1, 2};
        checks = 0;
        errors = 0;
        cyc = 0;
        rnd_gate = 1'b0;
        rst_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            active[i] = 1'b0;
            start[i] = 0;
            flen[i] = 0;
            fb[i] = '1;
            wh[i] = 0;
            wt[i] = 0;
        end

        // Directed words are already pending while reset is held, so tx_valid is high under reset.
        push(0, 9'h0A5);
        push(1, 9'h007);
        push(1, 9'h000);
        push(2, 9'h007);
        push(3, 9'h055);
        rst = 1'b1;
        drive();
        repeat (4) step();
        rst = 1'b0;
        repeat (120) step();

        // Back-to-back with tx_valid held; tx_data shows the next word while a frame is in flight.
        for (int i = 0; i < N; i++) begin
            push(i, 9'h001);
            push(i, 9'h080);
        end
        drive();
        repeat (130) step();

        // Reset during data bit 3 of instance 0, then a fresh word.
        push(0, 9'h03C);
        push(1, 9'h0C3);
        drive();
        for (int n = 0; n < 200 && !rst_hit; n++) begin
            step();
            if (active[0] && cyc - start[0] == 4 * cpb[0] + 1) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                rst_hit = 1'b1;
            end
        end
        check("rst_mid_frame_reached", 32'(rst_hit), 32'd1);
        push(0, 9'h096);
        push(3, 9'h07F);
        drive();
        repeat (100) step();

        rnd_gate = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (wh[i] == wt[i] && $urandom_range(0, 7) == 0) begin
                    repeat ($urandom_range(1, 3)) push(i, 9'($urandom));
                end
            end
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        repeat (60) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Parametrised UART transmitter that replaces the fixed 8N1 transmitter in the logger output path. It accepts a data word over a valid/ready handshake and serialises it LSB-first on `tx`. Frame format is set at elaboration: data width, parity mode and stop-bit count. It also pulses a completion flag per frame, so the log formatter upstream can pace and count transmitted bytes.

## Interface
- `CLKS_PER_BIT`, default `CLOCK_FREQ_HZ/BAUD_RATE` (shared constants): clock cycles per UART bit, must be ≥2.
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `PARITY`, default `PAR_NONE`: parity mode, one of `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_valid`  in  1  upstream has a word to send.
- `tx_data`  in  DATA_BITS  word to send; sampled only on acceptance.
- `tx_ready`  out  1  high when a word can be accepted (IDLE).
- `tx`  out  1  serial line; idles high.
- `tx_busy`  out  1  high while a frame is on the line (any state but IDLE).
- `frame_done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, `frame_done`=0; state IDLE; all counters 0.
- `rst` has priority. While `rst` is high, `tx_valid` is ignored.
- Acceptance: a rising edge where `tx_valid` and `tx_ready` are both 1.
  - On acceptance, `tx_data` is captured into the shift register.
  - Later changes on `tx_data` have no effect on the frame in flight.
- States: IDLE → START → DATA → PARITY → STOP → IDLE.
  - PARITY is skipped when `PARITY`=`PAR_NONE`.
- Line level per state:
  - START: `tx`=0.
  - DATA: `tx` = shift register bit 0, LSB first; the register shifts right once per bit.
  - PARITY: even → XOR of captured data; odd → inverted XOR.
  - STOP: `tx`=1 for `STOP_BITS` bit periods.
  - IDLE: `tx`=1.
- Bit timing: the baud counter runs 0..`CLKS_PER_BIT`-1 and wraps, giving an exact `CLKS_PER_BIT` cycles per bit with no drift.
  - The counter is zeroed on acceptance, so the start bit is full length.
- Bit index counter: counts 0..`DATA_BITS`-1 in DATA and 0..`STOP_BITS`-1 in STOP; cleared on each state change.
- Frame length: F = 1 + `DATA_BITS` + (parity ? 1 : 0) + `STOP_BITS` bits, i.e. F·`CLKS_PER_BIT` cycles.
- Reset mid-frame: abort immediately; `tx`=1 at the next edge; no `frame_done`; `tx_ready`=1.
- Elaboration checks (`$error`): `CLKS_PER_BIT`<2, `DATA_BITS` outside 5..9, `STOP_BITS` outside 1..2, illegal `PARITY`.

## Timing
- Acceptance at edge E:
  - `tx` falls to 0 and `tx_ready`/`tx_busy` switch (0/1) in the cycle after E.
  - `tx` stays 0 for exactly `CLKS_PER_BIT` cycles.
- All outputs are registered; nothing combinational from inputs reaches outputs.
- At the edge ending the final stop bit:
  - state returns to IDLE; `tx_ready`=1 and `tx_busy`=0 from the next cycle;
  - `frame_done`=1 for exactly that one cycle.
- Back-to-back: with `tx_valid` held high, the next word is accepted during the `frame_done` cycle.
  - Its start bit begins one cycle later, so the idle-high gap between frames is exactly 1 cycle.
- `tx_valid` deasserted before acceptance: nothing happens (no latching of a past request).

## Structure
- Shared package (existing state definitions header):
  - `tx_parity_t` enum (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`);
  - `uart_tx_state_t` enum;
  - existing `CLOCK_FREQ_HZ`, `BAUD_RATE`.
- Sub-module `baud_tick_gen`, parameter `CLKS_PER_BIT`:
  - inputs `clk`, `rst`, `clear`; output `tick` is a one-cycle pulse on counter wrap;
  - counter width is `$clog2(CLKS_PER_BIT)`.
- The FSM and shift register live in the top module.

## Test plan
- `CLKS_PER_BIT`=4, 8N1, send 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; 40 cycles total; `frame_done` pulses once, on the 40th cycle after the start bit begins.
- 8E1, send 0x07 → parity bit 1. 8O1, send 0x07 → parity bit 0. 8E1, send 0x00 → parity bit 0.
- 7N2, send 0x55 → `tx` = 0,1,0,1,0,1,0,1,1,1 (10 bits, 40 cycles); `tx_busy` high throughout.
- `tx_valid` held with 0x01 then 0x80 → second start bit falls exactly 1 cycle after `frame_done`; changing `tx_data` mid-frame leaves the frame unchanged.
- Assert `rst` during data bit 3 → `tx`=1 next cycle, `tx_ready`=1, no `frame_done`; the next accepted word is transmitted with correct timing.
- `tx_valid`=1 while `rst`=1 → no frame starts; `tx` stays 1.
